serial_subtractor_16bit: RTL and testbench

Multi-cycle unsigned subtractor. It computes diff = a − b − borrow_in one bit per clock, LSB first, and pairs with the combinational adder datapath as its inverse operation. It serves area-constrained datapaths that can tolerate BIT_WIDTH-cycle latency. Operands are captured on a start pulse, and completion is flagged with a one-cycle done pulse.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/serial_subtractor_16bit_if.sv | 27 ++
 rtl/full_subtractor_1bit.sv | 13 +
 rtl/serial_subtractor_16bit.sv | 128 ++++++++++++
 tb/tb_serial_subtractor_16bit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and default width for the serial subtractor
package serial_sub_pkg;

  localparam int SUB_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

endpackage

// File: rtl/serial_subtractor_16bit_if.sv
// rtl/serial_subtractor_16bit_if.sv - request/result bundle between a requester and the serial subtractor
interface serial_subtractor_16bit_if
  import serial_sub_pkg::*;
#(
  parameter int BIT_WIDTH = SUB_WIDTH
) ();

  logic                 start;
  logic [BIT_WIDTH-1:0] a;
  logic [BIT_WIDTH-1:0] b;
  logic                 borrow_in;
  logic                 busy;
  logic                 done;
  logic [BIT_WIDTH-1:0] diff;
  logic                 underflow;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, underflow
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, underflow
  );

endinterface

// File: rtl/full_subtractor_1bit.sv
// rtl/full_subtractor_1bit.sv - single-bit full subtractor, a - b - borrow_in
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor_16bit.sv
// rtl/serial_subtractor_16bit.sv - bit-serial unsigned subtractor, LSB first, one bit per clock
module serial_subtractor_16bit
  import serial_sub_pkg::*;
#(
  parameter int BIT_WIDTH = SUB_WIDTH
) (
  input  logic                      clk,
  input  logic                      n_rst,
  serial_subtractor_16bit_if.slave  sub_if
);

  localparam int               CNT_W    = $clog2(BIT_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIT_WIDTH - 1);

  sub_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0] a_sh_q, a_sh_d;
  logic [BIT_WIDTH-1:0] b_sh_q, b_sh_d;
  logic                 br_q, br_d;
  logic [BIT_WIDTH-1:0] part_q, part_d;
  logic [BIT_WIDTH-1:0] diff_q, diff_d;
  logic                 uf_q, uf_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 bit_diff;
  logic                 bit_borrow;
  logic                 start_accept;

  full_subtractor_1bit u_fsub (
    .a          (a_sh_q[0]),
    .b          (b_sh_q[0]),
    .borrow_in  (br_q),
    .diff       (bit_diff),
    .borrow_out (bit_borrow)
  );

  assign start_accept = sub_if.start && (state_q != SHIFT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    br_d    = br_q;
    part_d  = part_q;
    diff_d  = diff_q;
    uf_d    = uf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = bit_borrow;
        part_d = {bit_diff, part_q[BIT_WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        // Publish straight from the combinational shift so the last bit lands on this same edge.
        if (cnt_q == LAST_BIT) begin
          diff_d  = {bit_diff, part_q[BIT_WIDTH-1:1]};
          uf_d    = bit_borrow;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (sub_if.start) begin
          a_sh_d  = sub_if.a;
          b_sh_d  = sub_if.b;
          br_d    = sub_if.borrow_in;
          part_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      br_q    <= 1'b0;
      part_q  <= '0;
      diff_q  <= '0;
      uf_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      br_q    <= br_d;
      part_q  <= part_d;
      diff_q  <= diff_d;
      uf_q    <= uf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sub_if.busy      = busy_q;
  assign sub_if.done      = done_q;
  assign sub_if.diff      = diff_q;
  assign sub_if.underflow = uf_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (n_rst && start_accept) begin
      assert (!$isunknown(sub_if.a))
        else $error("Input 'a' is not a digital logic value");
      assert (!$isunknown(sub_if.b))
        else $error("Input 'b' is not a digital logic value");
      assert (!$isunknown(sub_if.borrow_in))
        else $error("Input 'borrow_in' is not a digital logic value");
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// tb/tb_serial_subtractor_16bit.sv - scoreboard bench for the serial subtractor
module tb_serial_subtractor_16bit;

  typedef struct {
    logic [15:0] diff;
    logic        uf;
    int          due;
  } exp_t;

  logic clk;
  logic n_rst;
  int   cyc;
  int   checks;
  int   errors;
  int   pushed;
  int   dones;
  exp_t sb[$];

  serial_subtractor_16bit_if #(.BIT_WIDTH(16)) sub_if ();

  serial_subtractor_16bit #(.BIT_WIDTH(16)) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .sub_if (sub_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (sub_if.done) begin
        dones++;
        chk("done_single_cycle", int'(prev_done), 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got done with diff 0x%0h, expected no result (cycle %0d)",
                   sub_if.diff, cyc);
        end else begin
          e = sb.pop_front();
          chk("diff", int'(sub_if.diff), int'(e.diff));
          chk("underflow", int'(sub_if.underflow), int'(e.uf));
          chk("latency", cyc, e.due);
        end
      end
      prev_done = sub_if.done;
    end
  endtask

  // Called at a negedge; E0 is the next posedge, done is seen 16 edges after that.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                       input logic [15:0] ed, input logic eu);
    sub_if.a         = av;
    sub_if.b         = bv;
    sub_if.borrow_in = bi;
    sub_if.start     = 1'b1;
    sb.push_back('{diff: ed, uf: eu, due: cyc + 17});
    pushed++;
    @(negedge clk);
    sub_if.start = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d results outstanding, expected 0", tag, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    pushed = 0;
    dones  = 0;
    n_rst  = 1'b0;
    sub_if.start     = 1'b0;
    sub_if.a         = '0;
    sub_if.b         = '0;
    sub_if.borrow_in = 1'b0;

    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(sub_if.busy), 0);
    chk("rst_done", int'(sub_if.done), 0);
    chk("rst_diff", int'(sub_if.diff), 0);
    chk("rst_underflow", int'(sub_if.underflow), 0);
    n_rst = 1'b1;
    @(negedge clk);

    issue(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0);
    chk("busy_after_start", int'(sub_if.busy), 1);
    wait_drain("v1");
    issue(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
    wait_drain("v2");
    issue(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    wait_drain("v3");
    issue(16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
    wait_drain("v4");
    issue(16'hA5A5, 16'h5A5A, 1'b1, 16'h4B4A, 1'b0);
    wait_drain("v5");

    // A second start while busy must be ignored entirely.
    issue(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0);
    repeat (3) @(negedge clk);
    chk("busy_mid_shift", int'(sub_if.busy), 1);
    sub_if.a     = 16'h0009;
    sub_if.b     = 16'h0001;
    sub_if.start = 1'b1;
    @(negedge clk);
    sub_if.start = 1'b0;
    wait_drain("ignored_start");
    chk("idle_after_done", int'(sub_if.busy), 0);

    // Back-to-back: re-issue in the DONE cycle.
    issue(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0);
    n = 0;
    while (!sub_if.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", int'(sub_if.done), 1);
    issue(16'h0010, 16'h0020, 1'b0, 16'hFFF0, 1'b1);
    chk("b2b_busy", int'(sub_if.busy), 1);
    chk("b2b_done_fell", int'(sub_if.done), 0);
    wait_drain("b2b");

    // Asynchronous reset mid-shift discards the operation.
    sub_if.a     = 16'h8000;
    sub_if.b     = 16'h0001;
    sub_if.start = 1'b1;
    @(negedge clk);
    sub_if.start = 1'b0;
    repeat (7) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_busy", int'(sub_if.busy), 0);
    chk("midrst_done", int'(sub_if.done), 0);
    chk("midrst_diff", int'(sub_if.diff), 0);
    chk("midrst_underflow", int'(sub_if.underflow), 0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_done_after_rst", int'(sub_if.diff), 0);
    issue(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0);
    wait_drain("post_rst");

    repeat (2) @(negedge clk);
    chk("done_count", dones, pushed);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
